uart_apb_arbiter: RTL and testbench

//  Round-robin APB3 master that shares the single uart_top APB3 slave port between NUM_REQ

---
 rtl/uart_apb_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_uart_apb_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_arbiter.sv
// Round-robin APB3 master that shares the single UART APB slave port between NUM_REQ requesters.
// Each grant becomes one APB3 transfer; a PREADY watchdog aborts ACCESS phases that never complete.
module uart_apb_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                               i_apb_pclk,
    input  logic                               i_apb_preset,
    input  logic [NUM_REQ-1:0]                 i_req,
    input  logic [NUM_REQ-1:0]                 i_req_write,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  i_req_addr,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  i_req_wdata,
    output logic [NUM_REQ-1:0]                 o_req_gnt,
    output logic [NUM_REQ-1:0]                 o_req_done,
    output logic [APB_DATA_WIDTH-1:0]          o_req_rdata,
    output logic                               o_req_err,
    output logic                               o_req_timeout,
    output logic                               o_busy,
    output logic [APB_ADDR_WIDTH-1:0]          o_apb_paddr,
    output logic [APB_DATA_WIDTH-1:0]          o_apb_pwdata,
    output logic                               o_apb_pwrite,
    output logic                               o_apb_psel,
    output logic                               o_apb_penable,
    input  logic [APB_DATA_WIDTH-1:0]          i_apb_prdata,
    input  logic                               i_apb_pready,
    input  logic                               i_apb_pslverr
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0]      LAST_INIT = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0]      CNT_MAX   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                    state_r, state_nxt_s;
    logic [IW-1:0]             last_r, last_nxt_s;
    logic [IW-1:0]             winner_r, winner_nxt_s;
    logic [CW-1:0]             cnt_r, cnt_nxt_s;
    logic [IW:0]               pick_res_s;
    logic                      pick_vld_s;
    logic [IW-1:0]             pick_idx_s;
    logic [NUM_REQ-1:0]        gnt_r, gnt_nxt_s;
    logic [NUM_REQ-1:0]        done_r, done_nxt_s;
    logic [APB_DATA_WIDTH-1:0] rdata_r, rdata_nxt_s;
    logic                      err_r, err_nxt_s;
    logic                      timeout_r, timeout_nxt_s;
    logic                      busy_r, busy_nxt_s;
    logic [APB_ADDR_WIDTH-1:0] paddr_r, paddr_nxt_s;
    logic [APB_DATA_WIDTH-1:0] pwdata_r, pwdata_nxt_s;
    logic                      pwrite_r, pwrite_nxt_s;
    logic                      psel_r, psel_nxt_s;
    logic                      penable_r, penable_nxt_s;

    // First requesting index after 'last', wrapping; MSB of the result flags a valid pick.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [IW-1:0] last);
        logic [IW:0] res;
        int          idx;
        res = {(IW+1){1'b0}};
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!res[IW] && req[idx]) begin
                res = {1'b1, IW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Arbitration result for the current request vector
    always_comb begin
        pick_res_s = rr_pick(i_req, last_r);
        pick_vld_s = pick_res_s[IW];
        pick_idx_s = pick_res_s[IW-1:0];
    end

    // Next-state and next-output logic for the transfer FSM
    always_comb begin
        state_nxt_s   = state_r;
        last_nxt_s    = last_r;
        winner_nxt_s  = winner_r;
        cnt_nxt_s     = cnt_r;
        gnt_nxt_s     = {NUM_REQ{1'b0}};
        done_nxt_s    = {NUM_REQ{1'b0}};
        rdata_nxt_s   = rdata_r;
        err_nxt_s     = 1'b0;
        timeout_nxt_s = 1'b0;
        paddr_nxt_s   = paddr_r;
        pwdata_nxt_s  = pwdata_r;
        pwrite_nxt_s  = pwrite_r;
        psel_nxt_s    = psel_r;
        penable_nxt_s = penable_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    paddr_nxt_s   = i_req_addr[int'(pick_idx_s)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                    pwdata_nxt_s  = i_req_wdata[int'(pick_idx_s)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                    pwrite_nxt_s  = i_req_write[pick_idx_s];
                    psel_nxt_s    = 1'b1;
                    penable_nxt_s = 1'b0;
                    gnt_nxt_s     = ONE_HOT0 << pick_idx_s;
                    last_nxt_s    = pick_idx_s;
                    winner_nxt_s  = pick_idx_s;
                    state_nxt_s   = ST_SETUP;
                end else begin
                    psel_nxt_s    = 1'b0;
                    penable_nxt_s = 1'b0;
                end
            end
            ST_SETUP: begin
                penable_nxt_s = 1'b1;
                cnt_nxt_s     = {CW{1'b0}};
                state_nxt_s   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (i_apb_pready) begin
                    psel_nxt_s    = 1'b0;
                    penable_nxt_s = 1'b0;
                    done_nxt_s    = ONE_HOT0 << winner_r;
                    err_nxt_s     = i_apb_pslverr;
                    state_nxt_s   = ST_IDLE;
                    if (!pwrite_r) begin
                        rdata_nxt_s = i_apb_prdata;
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                end else if (cnt_r == CNT_MAX) begin
                    // Watchdog abort: the slave never answered, release the bus with an error
                    psel_nxt_s    = 1'b0;
                    penable_nxt_s = 1'b0;
                    done_nxt_s    = ONE_HOT0 << winner_r;
                    err_nxt_s     = 1'b1;
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1'b1);
                end
            end
            default: begin
                psel_nxt_s    = 1'b0;
                penable_nxt_s = 1'b0;
                state_nxt_s   = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // FSM state and arbitration bookkeeping registers
    always_ff @(posedge i_apb_pclk or posedge i_apb_preset) begin
        if (i_apb_preset) begin
            state_r  <= ST_IDLE;
            last_r   <= LAST_INIT;
            winner_r <= {IW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            last_r   <= last_nxt_s;
            winner_r <= winner_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    // Registered requester-side and APB-side outputs
    always_ff @(posedge i_apb_pclk or posedge i_apb_preset) begin
        if (i_apb_preset) begin
            gnt_r     <= {NUM_REQ{1'b0}};
            done_r    <= {NUM_REQ{1'b0}};
            rdata_r   <= {APB_DATA_WIDTH{1'b0}};
            err_r     <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
            paddr_r   <= {APB_ADDR_WIDTH{1'b0}};
            pwdata_r  <= {APB_DATA_WIDTH{1'b0}};
            pwrite_r  <= 1'b0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
        end else begin
            gnt_r     <= gnt_nxt_s;
            done_r    <= done_nxt_s;
            rdata_r   <= rdata_nxt_s;
            err_r     <= err_nxt_s;
            timeout_r <= timeout_nxt_s;
            busy_r    <= busy_nxt_s;
            paddr_r   <= paddr_nxt_s;
            pwdata_r  <= pwdata_nxt_s;
            pwrite_r  <= pwrite_nxt_s;
            psel_r    <= psel_nxt_s;
            penable_r <= penable_nxt_s;
        end
    end

    assign o_req_gnt     = gnt_r;
    assign o_req_done    = done_r;
    assign o_req_rdata   = rdata_r;
    assign o_req_err     = err_r;
    assign o_req_timeout = timeout_r;
    assign o_busy        = busy_r;
    assign o_apb_paddr   = paddr_r;
    assign o_apb_pwdata  = pwdata_r;
    assign o_apb_pwrite  = pwrite_r;
    assign o_apb_psel    = psel_r;
    assign o_apb_penable = penable_r;

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Self-checking bench for uart_apb_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level round-robin reference model.
module tb_uart_apb_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt, done;
    logic [DW-1:0]   rdata;
    logic            err, tmo, busy;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic            pwrite, psel, penable;
    logic [DW-1:0]   prdata = '0;
    logic            pready = 1'b0;
    logic            pslverr = 1'b0;

    int total = 0;
    int bad   = 0;

    uart_apb_arbiter #(
        .NUM_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_apb_pclk(clk), .i_apb_preset(rst),
        .i_req(req), .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_req_gnt(gnt), .o_req_done(done), .o_req_rdata(rdata), .o_req_err(err),
        .o_req_timeout(tmo), .o_busy(busy),
        .o_apb_paddr(paddr), .o_apb_pwdata(pwdata), .o_apb_pwrite(pwrite),
        .o_apb_psel(psel), .o_apb_penable(penable),
        .i_apb_prdata(prdata), .i_apb_pready(pready), .i_apb_pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned wait_n;
        logic        slverr;
        logic [31:0] prdata;
        logic        exp_err;
        logic        exp_to;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 99;
    endfunction

    task automatic set_req(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_write[k]        = wr;
        req_addr[k*AW +: AW]  = a;
        req_wdata[k*DW +: DW] = d;
        req[k]              = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
        step();
        chk("rst_ctl", {gnt, done, err, tmo, busy, psel, penable, pwrite}, 64'd0);
        chk("rst_bus", {paddr, pwdata}, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        step();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int acc;
        set_req(int'(v.req), v.wr, v.addr, v.wdata);
        pready = 1'b0; pslverr = 1'b0; prdata = 32'hFFFF_FFFF;
        step();
        chk("v_gnt", gnt, oh(int'(v.req)));
        chk("v_setup", {psel, penable, busy}, 3'b101);
        chk("v_paddr", paddr, v.addr);
        chk("v_pwdata", pwdata, v.wdata);
        chk("v_pwrite", pwrite, v.wr);
        req[v.req] = 1'b0;
        step();
        chk("v_gnt_clr", gnt, 0);
        acc = (v.wait_n < TO) ? int'(v.wait_n) + 1 : TO;
        for (int i = 0; i < acc; i++) begin
            chk("v_access", {psel, penable, done}, {2'b11, 3'b000});
            chk("v_stable", {paddr, pwdata}, {v.addr, v.wdata});
            chk("v_stable_wr", pwrite, v.wr);
            pready  = (i == int'(v.wait_n));
            prdata  = pready ? v.prdata : 32'hFFFF_FFFF;
            pslverr = pready ? v.slverr : 1'b1;
            step();
        end
        pready = 1'b0; pslverr = 1'b0;
        chk("v_done", done, oh(int'(v.req)));
        chk("v_err", err, v.exp_err);
        chk("v_timeout", tmo, v.exp_to);
        chk("v_rdata", rdata, v.exp_rdata);
        chk("v_idle", {psel, penable, busy}, 3'b000);
        step();
        chk("v_pulse_clr", {done, err, tmo}, 0);
        chk("v_rdata_hold", rdata, v.exp_rdata);
    endtask

    vec_t vt[7];
    int   gq[$];
    int   order[$];
    int   nd, t, owner, g_cyc, w_n, done_cyc, win;
    int   dly[N];
    bit   active, free, tmo_exp;
    logic wr_l, serr_l;
    logic [31:0] addr_l, wd_l, prd_l, rd_model;
    logic [N-1:0] pred_g;

    initial begin
        // req, wr, addr, wdata, wait, slverr, prdata, exp_err, exp_to, exp_rdata
        vt[0] = '{0, 1'b1, 32'h04, 32'h0000_00A5, 0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
        vt[1] = '{1, 1'b0, 32'h10, 32'h0,         5,  1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vt[2] = '{0, 1'b0, 32'h14, 32'h0,         99, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 32'hDEAD_BEEF};
        vt[3] = '{1, 1'b1, 32'h18, 32'h0000_005A, 0,  1'b1, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF};
        vt[4] = '{2, 1'b0, 32'h1C, 32'h0,         2,  1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0BAD_F00D};
        vt[5] = '{2, 1'b1, 32'h20, 32'hCAFE_0001, 7,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0BAD_F00D};
        vt[6] = '{0, 1'b0, 32'h24, 32'h0,         6,  1'b0, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_0055};

        do_reset();
        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Two readers held continuously: strict alternation, 3 cycles per transfer
        do_reset();
        set_req(0, 1'b0, 32'h08, 32'h0);
        set_req(1, 1'b0, 32'h0C, 32'h0);
        gq.delete(); nd = 0;
        for (int c = 0; c < 14; c++) begin
            step();
            if (gnt != 0) gq.push_back(idx_of(gnt));
            if (done != 0) begin
                nd++;
                chk("t2_rdata", rdata, (done == 3'b001) ? 32'h11 : 32'h22);
            end
            if (psel && penable) begin
                pready = 1'b1;
                prdata = (paddr == 32'h08) ? 32'h11 : ((paddr == 32'h0C) ? 32'h22 : 32'h0);
            end else begin
                pready = 1'b0;
                prdata = 32'hFFFF_FFFF;
            end
        end
        chk("t2_ngnt", gq.size(), 5);
        chk("t2_ndone", nd, 4);
        for (int i = 0; i < 4; i++) chk("t2_order", (i < gq.size()) ? gq[i] : 99, i % 2);

        // Reset in the middle of ACCESS, then requester 0 must win again
        do_reset();
        set_req(0, 1'b1, 32'h30, 32'h77);
        step(); req = '0;
        step(); step();
        chk("t6_pre", {psel, penable}, 2'b11);
        rst = 1'b1;
        #1;
        chk("t6_async_ctl", {gnt, done, err, tmo, busy, psel, penable, pwrite}, 64'd0);
        chk("t6_async_bus", {paddr, pwdata}, 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_quiet", {done, busy, psel}, 0);
        end
        set_req(0, 1'b1, 32'h40, 32'h1); set_req(1, 1'b1, 32'h44, 32'h2);
        step();
        chk("t6_first", gnt, 3'b001);
        req = '0;

        // Randomized traffic against a transaction-level round-robin model
        do_reset();
        order = {0, 1, 2};
        free = 1'b1; active = 1'b0; rd_model = '0; g_cyc = 0; done_cyc = 0; owner = 0; w_n = 0;
        wr_l = 1'b0; serr_l = 1'b0; addr_l = '0; wd_l = '0; prd_l = '0;
        for (int k = 0; k < N; k++) dly[k] = 0;
        for (int c = 1; c <= 3000; c++) begin
            pred_g = '0; win = -1;
            if (free && req != 0) begin
                foreach (order[j]) if (win < 0 && req[order[j]]) win = order[j];
                pred_g = oh(win);
            end
            step();
            chk("rnd_gnt", gnt, pred_g);
            if (win >= 0) begin
                chk("rnd_paddr", paddr, req_addr[win*AW +: AW]);
                chk("rnd_pwdata", pwdata, req_wdata[win*DW +: DW]);
                chk("rnd_pwrite", pwrite, req_write[win]);
                active = 1'b1; free = 1'b0; owner = win; g_cyc = c;
                addr_l = req_addr[win*AW +: AW]; wd_l = req_wdata[win*DW +: DW]; wr_l = req_write[win];
                w_n = ($urandom_range(0, 7) == 0) ? 50 : int'($urandom_range(0, 4));
                done_cyc = c + 1 + ((w_n < TO) ? w_n + 1 : TO);
                prd_l = $urandom; serr_l = ($urandom_range(0, 3) == 0);
                while (order[$] != win) begin
                    t = order.pop_front();
                    order.push_back(t);
                end
                req[win] = 1'b0; dly[win] = int'($urandom_range(0, 6));
            end
            if (active && c == done_cyc) begin
                tmo_exp = (w_n >= TO);
                chk("rnd_done", done, oh(owner));
                chk("rnd_err", err, tmo_exp | serr_l);
                chk("rnd_timeout", tmo, tmo_exp);
                if (!tmo_exp && !wr_l) rd_model = prd_l;
                chk("rnd_rdata", rdata, rd_model);
                chk("rnd_idle", {psel, penable, busy}, 3'b000);
                active = 1'b0; free = 1'b1;
            end else begin
                chk("rnd_nodone", {done, err, tmo}, 0);
                chk("rnd_rdata_hold", rdata, rd_model);
                chk("rnd_bus", {psel, penable, busy}, active ? {1'b1, 1'(c > g_cyc), 1'b1} : 3'b000);
                if (active) chk("rnd_stable", {pwrite, paddr, pwdata}, {wr_l, addr_l, wd_l});
            end
            if (active && c > g_cyc) begin
                pready  = (c - g_cyc - 1 == w_n);
                prdata  = pready ? prd_l : $urandom;
                pslverr = pready ? serr_l : 1'($urandom_range(0, 1));
            end else begin
                pready  = 1'($urandom_range(0, 1));
                prdata  = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end
            for (int k = 0; k < N; k++) begin
                if (!req[k]) begin
                    if (dly[k] > 0) dly[k]--;
                    else if ($urandom_range(0, 2) == 0) set_req(k, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req[k] = 1'b0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
